// File: rtl/cp0_tlb_pkg.sv
// -----------------------------------------------------------------------------
// cp0_tlb_pkg
// Shared CP0/TLB definitions: CP0 register numbers for the Random/Wired pair,
// the default TLB depth and the helper that derives the TLB index width.
// -----------------------------------------------------------------------------
package cp0_tlb_pkg;

    // CP0 register numbers as seen by the MFC0/MTC0 decode.
    typedef enum logic [4:0] {
        CP0_RANDOM = 5'd1,
        CP0_WIRED  = 5'd6
    } cp0_reg_e;

    localparam int TLB_ENTRIES_DEFAULT = 16;

    // Bits needed to index a TLB of n entries.
    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

    localparam int IDX_W_DEFAULT = idx_width(TLB_ENTRIES_DEFAULT);

endpackage : cp0_tlb_pkg

// File: rtl/cp0_wired_random_if.sv
// -----------------------------------------------------------------------------
// cp0_wired_random_if
// Bundle between the CP0 pipeline control and the Wired/Random register pair.
//   stall     : pipeline freeze (Random holds)
//   wired_we  : MTC0 write strobe to Wired
//   mtcd      : MTC0 write data (low IDX_W bits used)
//   tlbwr     : TLBWR retire pulse
//   wired_q   : Wired, zero-extended to 32 bits
//   random_q  : Random, zero-extended to 32 bits
//   tlbwr_idx : Random as the TLBWR replacement index
// master = pipeline side, slave = register pair.
// -----------------------------------------------------------------------------
interface cp0_wired_random_if #(
    parameter int IDX_W = cp0_tlb_pkg::IDX_W_DEFAULT
);
    logic             stall;
    logic             wired_we;
    logic [31:0]      mtcd;
    logic             tlbwr;
    logic [31:0]      wired_q;
    logic [31:0]      random_q;
    logic [IDX_W-1:0] tlbwr_idx;

    modport master (
        output stall, wired_we, mtcd, tlbwr,
        input  wired_q, random_q, tlbwr_idx
    );

    modport slave (
        input  stall, wired_we, mtcd, tlbwr,
        output wired_q, random_q, tlbwr_idx
    );
endinterface : cp0_wired_random_if

// File: rtl/cp0_wired_random_counter.sv
// -----------------------------------------------------------------------------
// cp0_random_counter
// Down-counter over [i_lower, TLB_ENTRIES-1] that wraps to the top once it has
// reached (or is at/below) the lower bound.
//   clk, rst   : clock, synchronous active-high reset (loads the top value)
//   i_load_max : force the count to TLB_ENTRIES-1 (wins over i_advance)
//   i_advance  : step the counter this cycle
//   i_lower    : lower bound (current Wired value)
//   o_count    : registered count
// -----------------------------------------------------------------------------
module cp0_random_counter
    import cp0_tlb_pkg::*;
#(
    parameter int TLB_ENTRIES = TLB_ENTRIES_DEFAULT,
    parameter int IDX_W       = idx_width(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load_max,
    input  logic             i_advance,
    input  logic [IDX_W-1:0] i_lower,
    output logic [IDX_W-1:0] o_count
);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(TLB_ENTRIES - 1);

    logic [IDX_W-1:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent sim races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= MAX_IDX;
        end else if (i_load_max) begin
            r_count <= MAX_IDX;
        end else if (i_advance) begin
            // "<=" rather than "==" also recovers if the bound was raised
            // above the count; it keeps the count inside [lower, MAX].
            if (r_count <= i_lower) begin
                r_count <= MAX_IDX;
            end else begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_count = r_count;

endmodule : cp0_random_counter

// File: rtl/cp0_wired_random.sv
// -----------------------------------------------------------------------------
// cp0_wired_random
// CP0 Wired (reg 6) and Random (reg 1) pair for a TLB of TLB_ENTRIES entries.
// Wired counts locked low TLB entries; Random cycles down through
// [Wired, TLB_ENTRIES-1] and provides the TLBWR replacement index.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : cp0_wired_random_if.slave (stall, wired_we, mtcd, tlbwr in;
//         wired_q, random_q, tlbwr_idx out), all outputs registered.
// Build option: define CP0_TLBWR_ADVANCE_EN to advance Random only on an
// unstalled TLBWR retire; by default it advances on every unstalled cycle.
// -----------------------------------------------------------------------------
module cp0_wired_random
    import cp0_tlb_pkg::*;
#(
    parameter int TLB_ENTRIES = TLB_ENTRIES_DEFAULT,
    parameter int IDX_W       = idx_width(TLB_ENTRIES)
) (
    input  logic                     clk,
    input  logic                     rst,
    cp0_wired_random_if.slave        bus
);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(TLB_ENTRIES - 1);

    logic [IDX_W-1:0] r_wired;
    logic [IDX_W-1:0] w_wr_val;
    logic [IDX_W-1:0] w_random;
    logic             w_advance;
    logic             w_unused;

    // Indices past the last entry only exist for non-power-of-two depths.
    generate
        if ((TLB_ENTRIES & (TLB_ENTRIES - 1)) != 0) begin : g_clamp
            always_comb begin
                // NOTE: give every always_comb output a default first so no
                // path leaves it unassigned, which would infer a latch.
                w_wr_val = bus.mtcd[IDX_W-1:0];
                if (bus.mtcd[IDX_W-1:0] > MAX_IDX) begin
                    w_wr_val = MAX_IDX;
                end
            end
        end else begin : g_no_clamp
            assign w_wr_val = bus.mtcd[IDX_W-1:0];
        end
    endgenerate

`ifdef CP0_TLBWR_ADVANCE_EN
    assign w_advance = bus.tlbwr & ~bus.stall;
`else
    assign w_advance = ~bus.stall;
`endif

    // Upper MTC0 data bits are ignored; tlbwr only matters with the option.
    assign w_unused = &{1'b0, bus.mtcd[31:IDX_W], bus.tlbwr};

    // Wired writes are not gated by stall: squashed MTC0s never raise wired_we.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wired <= '0;
        end else if (bus.wired_we) begin
            r_wired <= w_wr_val;
        end
    end

    // The wrap test uses the old Wired; a Wired write reloads Random anyway.
    cp0_random_counter #(
        .TLB_ENTRIES (TLB_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_random (
        .clk        (clk),
        .rst        (rst),
        .i_load_max (bus.wired_we),
        .i_advance  (w_advance),
        .i_lower    (r_wired),
        .o_count    (w_random)
    );

    assign bus.wired_q   = {{(32 - IDX_W){1'b0}}, r_wired};
    assign bus.random_q  = {{(32 - IDX_W){1'b0}}, w_random};
    assign bus.tlbwr_idx = w_random;

endmodule : cp0_wired_random

// File: tb/tb_cp0_wired_random.sv
// -----------------------------------------------------------------------------
// tb_cp0_wired_random
// Self-checking bench for cp0_wired_random (TLB_ENTRIES = 16).
// A reference model tracks Wired/Random as plain integers from the register
// rules; a negedge process compares every DUT output against it. Directed
// phases pin the model with literal values, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_cp0_wired_random;
    localparam int N     = 16;
    localparam int IDX_W = 4;

    logic clk;
    logic rst;

    cp0_wired_random_if #(.IDX_W(IDX_W)) bus ();

    cp0_wired_random #(
        .TLB_ENTRIES (N),
        .IDX_W       (IDX_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_wired;
    int m_random;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int  v;
        bit  adv;
        if (rst === 1'b1) begin
            m_wired  = 0;
            m_random = N - 1;
            m_valid  = 1'b1;
        end else if (m_valid) begin
`ifdef CP0_TLBWR_ADVANCE_EN
            adv = bus.tlbwr && !bus.stall;
`else
            adv = !bus.stall;
`endif
            if (bus.wired_we) begin
                v = int'(bus.mtcd % N);
                m_wired  = (v > N - 1) ? N - 1 : v;
                m_random = N - 1;
            end else if (adv) begin
                m_random = (m_random <= m_wired) ? N - 1 : m_random - 1;
            end
        end
    end

    // Single compare process: every cycle once the model is known.
    always @(negedge clk) begin
        if (m_valid) begin
            check("wired_q",   bus.wired_q,  32'(m_wired));
            check("random_q",  bus.random_q, 32'(m_random));
            check("tlbwr_idx", 32'(bus.tlbwr_idx), 32'(m_random));
            check("invariant", 32'((m_wired <= int'(bus.random_q)) &&
                                   (int'(bus.random_q) <= N - 1)), 32'd1);
        end
    end

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst          = 1'b0;
        bus.stall    = 1'b0;
        bus.wired_we = 1'b0;
        bus.mtcd     = 32'h0;
        bus.tlbwr    = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check("rst_wired",  bus.wired_q,  32'd0);
        check("rst_random", bus.random_q, 32'd15);
        rst = 1'b0;

`ifndef CP0_TLBWR_ADVANCE_EN
        // WIRED = 0: full period 14..0 then wrap to 15.
        for (int i = 0; i < 16; i++) begin
            tick();
            check("run_w0", bus.random_q, (i <= 14) ? 32'(14 - i) : 32'd15);
        end

        // Wired write with junk upper bits.
        bus.wired_we = 1'b1;
        bus.mtcd     = 32'hFFFF_FFF5;
        tick();
        bus.wired_we = 1'b0;
        check("wr_wired",  bus.wired_q,  32'd5);
        check("wr_random", bus.random_q, 32'd15);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("run_w5", bus.random_q,
                  (i < 10) ? 32'(14 - i) : ((i == 10) ? 32'd15 : 32'd14));
        end

        // Stall hold at RANDOM = 9.
        repeat (5) tick();
        check("pre_stall", bus.random_q, 32'd9);
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_hold", bus.random_q, 32'd9);
        end
        bus.stall = 1'b0;
        tick();
        check("stall_rel", bus.random_q, 32'd8);

        // Wired write + stall in the same cycle as RANDOM = 7.
        tick();
        check("pre_sim", bus.random_q, 32'd7);
        bus.wired_we = 1'b1;
        bus.mtcd     = 32'd3;
        bus.stall    = 1'b1;
        tick();
        bus.wired_we = 1'b0;
        bus.stall    = 1'b0;
        check("sim_wired",  bus.wired_q,  32'd3);
        check("sim_random", bus.random_q, 32'd15);
        tick();
        check("sim_next", bus.random_q, 32'd14);

        // Pinned boundary WIRED = 15.
        bus.wired_we = 1'b1;
        bus.mtcd     = 32'd15;
        tick();
        bus.wired_we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("pinned", bus.random_q, 32'd15);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_wired",  bus.wired_q,  32'd0);
        check("mid_rst_random", bus.random_q, 32'd15);
        tick();
        check("mid_rst_next", bus.random_q, 32'd14);
`else
        // Random only steps on unstalled TLBWR retires.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_hold", bus.random_q, 32'd15);
        end
        bus.tlbwr = 1'b1;
        tick();
        bus.stall = 1'b1;
        tick();
        bus.stall = 1'b0;
        tick();
        bus.tlbwr = 1'b0;
        tick();
        check("tlbwr_adv", bus.random_q, 32'd13);
`endif

        // Randomized phase, checked by the compare process.
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(63) == 0);
            bus.wired_we = ($urandom_range(15) == 0);
            bus.mtcd     = ($urandom_range(1) == 0) ? $urandom : 32'($urandom_range(N - 1));
            bus.stall    = ($urandom_range(3) == 0);
            bus.tlbwr    = ($urandom_range(1) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cp0_wired_random
